// File: rtl/peripheral_burst_master_axi4.sv
// Bus-master front end for the single-port RAM slave.
// Turns command / write-data / read-data streams into registered-feedback
// bus cycles: classic single transfers or incrementing bursts with
// linear / wrap-4/8/16 addressing, closed by an end-of-burst CTI.
// Write data is staged in a MAXLEN-deep FIFO, and a write burst starts only
// once all of its beats are buffered, so it runs without bubbles.
//
// Ports:
//   axi4_clk_i / axi4_rst_i       clock, async active-low reset
//   cmd_*                         command stream (valid/ready)
//   wdat_*                        write-data stream into the FIFO
//   rdat_valid_o / rdat_o         read beats, one pulse each, no backpressure
//   done_o / err_o                completion pulse, err_o qualifies it
//   axi4_*_o / axi4_*_i           bus request / response
module peripheral_burst_master_axi4 #(
  parameter int DW     = 32,
  parameter int AW     = 8,
  parameter int MAXLEN = 16,
  parameter int LW     = $clog2(MAXLEN+1)
) (
  input  logic            axi4_clk_i,
  input  logic            axi4_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic            cmd_we_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic [1:0]      cmd_bte_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  input  logic            wdat_valid_i,
  output logic            wdat_ready_o,
  input  logic [DW-1:0]   wdat_i,
  output logic            rdat_valid_o,
  output logic [DW-1:0]   rdat_o,
  output logic            done_o,
  output logic            err_o,
  output logic [AW-1:0]   axi4_adr_o,
  output logic [DW-1:0]   axi4_dat_o,
  output logic [DW/8-1:0] axi4_sel_o,
  output logic            axi4_we_o,
  output logic [1:0]      axi4_bte_o,
  output logic [2:0]      axi4_cti_o,
  output logic            axi4_cyc_o,
  output logic            axi4_stb_o,
  input  logic            axi4_ack_i,
  input  logic            axi4_err_i,
  input  logic [DW-1:0]   axi4_dat_i
);
  localparam int SH = $clog2(DW/8);   // byte-offset bits within a beat
  localparam int BW = AW - SH;        // beat-index bits
  localparam int PW = $clog2(MAXLEN); // FIFO pointer bits

  typedef enum logic [1:0] {IDLE, WAIT_DATA, ACTIVE, FINISH} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic              we_q, we_d;
  logic [LW-1:0]     len_q, len_d;
  logic [1:0]        bte_q, bte_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic [LW-1:0]     left_q, left_d;
  logic              err_q, err_d;
  logic [LW-1:0]     drain_q, drain_d;   // entries still to discard after a write error
  logic              rvld_q, rvld_d;
  logic [DW-1:0]     rdat_q, rdat_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     mem_q [MAXLEN];
  logic              push, pop, active;

  // Next beat address: linear increments the whole beat index, wrap-N only
  // its low log2(N) bits. Byte-offset bits are carried through untouched.
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [BW-1:0] b, mask;
    logic [AW-1:0] r;
    b = a[AW-1:SH];
    case (bte)
      2'd1:    mask = BW'(3);
      2'd2:    mask = BW'(7);
      2'd3:    mask = BW'(15);
      default: mask = '1;
    endcase
    r = a;
    r[AW-1:SH] = (b & ~mask) | ((b + BW'(1)) & mask);
    return r;
  endfunction

  // FIFO bookkeeping
  assign push     = wdat_valid_i & wdat_ready_o;
  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign cnt_d    = cnt_q + LW'(push) - LW'(pop);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    len_d   = len_q;
    bte_d   = bte_q;
    sel_d   = sel_q;
    left_d  = left_q;
    err_d   = err_q;
    drain_d = drain_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        adr_d   = cmd_adr_i;
        we_d    = cmd_we_i;
        len_d   = cmd_len_i;
        bte_d   = cmd_bte_i;
        sel_d   = cmd_sel_i;
        left_d  = cmd_len_i;
        err_d   = 1'b0;
        drain_d = '0;
        if (cmd_len_i == '0) begin
          state_d = FINISH;
        end else if (cmd_len_i > LW'(MAXLEN)) begin
          state_d = FINISH;
          err_d   = 1'b1;
        end else if (cmd_we_i && (cnt_q < cmd_len_i)) begin
          state_d = WAIT_DATA;
        end else begin
          state_d = ACTIVE;
        end
      end
      WAIT_DATA: if (cnt_q >= len_q) state_d = ACTIVE;
      ACTIVE: begin
        if (axi4_err_i) begin
          // The failed beat's own entry goes now; the rest drain in FINISH.
          state_d = FINISH;
          err_d   = 1'b1;
          pop     = we_q;
          drain_d = we_q ? left_q - LW'(1) : '0;
        end else if (axi4_ack_i) begin
          pop    = we_q;
          left_d = left_q - LW'(1);
          adr_d  = next_adr(adr_q, bte_q);
          if (left_q == LW'(1)) state_d = FINISH;
        end
      end
      FINISH: begin
        if (drain_q != '0) begin
          pop     = 1'b1;
          drain_d = drain_q - LW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active       = (state_q == ACTIVE);
    cmd_ready_o  = (state_q == IDLE);
    wdat_ready_o = (cnt_q != LW'(MAXLEN));
    axi4_cyc_o   = active;
    axi4_stb_o   = active;
    axi4_adr_o   = active ? adr_q : '0;
    axi4_we_o    = active & we_q;
    axi4_sel_o   = active ? sel_q : '0;
    axi4_bte_o   = active ? bte_q : '0;
    axi4_dat_o   = (active && we_q) ? mem_q[rd_ptr_q] : '0;
    axi4_cti_o   = 3'b000;
    if (active && len_q != LW'(1)) axi4_cti_o = (left_q == LW'(1)) ? 3'b111 : 3'b010;
    done_o       = (state_q == FINISH) && (drain_q == '0);
    err_o        = done_o & err_q;
    rvld_d       = axi4_ack_i & axi4_cyc_o & axi4_stb_o & ~axi4_we_o;
    rdat_d       = rvld_d ? axi4_dat_i : rdat_q;
    rdat_valid_o = rvld_q;
    rdat_o       = rdat_q;
  end

  always_ff @(posedge axi4_clk_i or negedge axi4_rst_i) begin
    if (!axi4_rst_i) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      we_q     <= 1'b0;
      len_q    <= '0;
      bte_q    <= '0;
      sel_q    <= '0;
      left_q   <= '0;
      err_q    <= 1'b0;
      drain_q  <= '0;
      rvld_q   <= 1'b0;
      rdat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      len_q    <= len_d;
      bte_q    <= bte_d;
      sel_q    <= sel_d;
      left_q   <= left_d;
      err_q    <= err_d;
      drain_q  <= drain_d;
      rvld_q   <= rvld_d;
      rdat_q   <= rdat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge axi4_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdat_i;
  end
endmodule

// File: tb/tb_peripheral_burst_master_axi4.sv
module tb_peripheral_burst_master_axi4;
  localparam int DW = 32, AW = 8, MAXLEN = 16, LW = 5;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            cmd_valid_i = 0, cmd_ready_o, cmd_we_i = 0;
  logic [AW-1:0]   cmd_adr_i = '0;
  logic [LW-1:0]   cmd_len_i = '0;
  logic [1:0]      cmd_bte_i = '0;
  logic [3:0]      cmd_sel_i = '0;
  logic            wdat_valid_i = 0, wdat_ready_o;
  logic [DW-1:0]   wdat_i = '0;
  logic            rdat_valid_o, done_o, err_o;
  logic [DW-1:0]   rdat_o, axi4_dat_o, axi4_dat_i;
  logic [AW-1:0]   axi4_adr_o;
  logic [3:0]      axi4_sel_o;
  logic            axi4_we_o, axi4_cyc_o, axi4_stb_o, axi4_ack_i, axi4_err_i;
  logic [1:0]      axi4_bte_o;
  logic [2:0]      axi4_cti_o;

  peripheral_burst_master_axi4 #(.DW(DW), .AW(AW), .MAXLEN(MAXLEN), .LW(LW)) dut (
    .axi4_clk_i(clk), .axi4_rst_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr_i),
    .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i), .cmd_sel_i(cmd_sel_i),
    .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .done_o(done_o), .err_o(err_o),
    .axi4_adr_o(axi4_adr_o), .axi4_dat_o(axi4_dat_o), .axi4_sel_o(axi4_sel_o),
    .axi4_we_o(axi4_we_o), .axi4_bte_o(axi4_bte_o), .axi4_cti_o(axi4_cti_o),
    .axi4_cyc_o(axi4_cyc_o), .axi4_stb_o(axi4_stb_o),
    .axi4_ack_i(axi4_ack_i), .axi4_err_i(axi4_err_i), .axi4_dat_i(axi4_dat_i)
  );

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- RAM slave: registered-feedback ack, optional error beat
  logic [7:0] smem [256];
  logic       ack_q, ack_raw, inject;
  int         slv_beat, inj_beat = 0;
  assign ack_raw    = ack_q & axi4_cyc_o & axi4_stb_o;
  assign inject     = (inj_beat != 0) && (slv_beat + 1 == inj_beat);
  assign axi4_ack_i = ack_raw & ~inject;
  assign axi4_err_i = ack_raw & inject;
  assign axi4_dat_i = {smem[{axi4_adr_o[7:2], 2'd3}], smem[{axi4_adr_o[7:2], 2'd2}],
                       smem[{axi4_adr_o[7:2], 2'd1}], smem[{axi4_adr_o[7:2], 2'd0}]};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      slv_beat <= 0;
      for (int i = 0; i < 256; i++) smem[i] <= 8'(i * 37 + 5);
    end else begin
      ack_q <= axi4_cyc_o & axi4_stb_o & ~axi4_err_i &
               ~(ack_raw & (axi4_cti_o == 3'b000 || axi4_cti_o == 3'b111));
      if (!axi4_cyc_o) slv_beat <= 0;
      else if (ack_raw) slv_beat <= slv_beat + 1;
      if (axi4_ack_i && axi4_we_o)
        for (int i = 0; i < 4; i++)
          if (axi4_sel_o[i]) smem[{axi4_adr_o[7:2], 2'(i)}] <= axi4_dat_o[8*i +: 8];
    end
  end

  // ---------------- reference model and scoreboard
  typedef struct packed {
    logic [7:0] adr; logic we; logic [3:0] sel; logic [2:0] cti;
    logic [1:0] bte; logic [31:0] dat; logic err;
  } beat_t;

  beat_t       bq[$];
  logic [31:0] rq[$];
  logic        dq[$];
  logic [31:0] wq[$];
  logic [7:0]  rmem [256];
  int          n_chk = 0, n_fail = 0;
  bit          mon_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_chk++; n_fail++;
    $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
  endtask

  task automatic mem_init();
    for (int i = 0; i < 256; i++) rmem[i] = 8'(i * 37 + 5);
  endtask

  function automatic logic [7:0] beat_adr(input logic [7:0] a, input logic [1:0] bte, input int k);
    int b0, n, b;
    b0 = int'(a) >> 2;
    if (bte == 2'd0) b = (b0 + k) % 64;
    else begin
      n = 2 << bte;
      b = (b0 / n) * n + ((b0 % n) + k) % n;
    end
    return 8'((b << 2) | (int'(a) & 3));
  endfunction

  function automatic logic [31:0] rword(input logic [7:0] a);
    return {rmem[{a[7:2], 2'd3}], rmem[{a[7:2], 2'd2}], rmem[{a[7:2], 2'd1}], rmem[{a[7:2], 2'd0}]};
  endfunction

  // Expected bus beats, read data and completion status for one command.
  task automatic expect_cmd(input logic [7:0] adr, input logic we, input int len,
                            input logic [1:0] bte, input logic [3:0] sel, input int errb);
    beat_t b;
    logic [31:0] d[$];
    logic [7:0] a;
    if (len == 0 || len > MAXLEN) begin
      dq.push_back(len > MAXLEN);
      return;
    end
    if (we) for (int k = 0; k < len; k++) d.push_back(wq.pop_front());
    for (int k = 0; k < len; k++) begin
      a = beat_adr(adr, bte, k);
      b.adr = a; b.we = we; b.sel = sel; b.bte = bte;
      b.cti = (len == 1) ? 3'b000 : (k == len - 1) ? 3'b111 : 3'b010;
      b.dat = we ? d[k] : 32'h0;
      b.err = (errb == k + 1);
      bq.push_back(b);
      if (b.err) break;
      if (we) begin
        for (int i = 0; i < 4; i++) if (sel[i]) rmem[{a[7:2], 2'(i)}] = d[k][8*i +: 8];
      end else rq.push_back(rword(a));
    end
    dq.push_back(errb != 0);
  endtask

  always @(negedge clk) begin : monitor
    beat_t e;
    if (mon_en) begin
      if (axi4_cyc_o && axi4_stb_o && (axi4_ack_i || axi4_err_i)) begin
        if (bq.size() == 0) fail_evt("bus_beat");
        else begin
          e = bq.pop_front();
          chk("beat_adr", axi4_adr_o, e.adr);
          chk("beat_cti", axi4_cti_o, e.cti);
          chk("beat_we_sel_bte", {axi4_we_o, axi4_sel_o, axi4_bte_o}, {e.we, e.sel, e.bte});
          chk("beat_err", axi4_err_i, e.err);
          if (e.we) chk("beat_wdat", axi4_dat_o, e.dat);
        end
      end
      if (rdat_valid_o) begin
        if (rq.size() == 0) fail_evt("rdat");
        else chk("rdat", rdat_o, rq.pop_front());
      end
      if (done_o) begin
        if (dq.size() == 0) fail_evt("done");
        else chk("done_err", err_o, dq.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic push(input logic [31:0] d);
    @(negedge clk);
    wdat_valid_i = 1; wdat_i = d;
    @(posedge clk); #1;
    wdat_valid_i = 0;
  endtask

  task automatic issue(input logic [7:0] adr, input logic we, input int len,
                       input logic [1:0] bte, input logic [3:0] sel, output int t);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready_o && w < 100) begin @(negedge clk); w++; end
    chk("cmd_ready_before_issue", cmd_ready_o, 1);
    cmd_valid_i = 1; cmd_adr_i = adr; cmd_we_i = we; cmd_len_i = LW'(len);
    cmd_bte_i = bte; cmd_sel_i = sel;
    @(posedge clk); #1;
    cmd_valid_i = 0;
    t = cyc_cnt;
  endtask

  task automatic wait_done(input int t, input int lat);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (n < 400 && !seen) begin
      @(negedge clk);
      if (done_o) seen = 1; else n++;
    end
    chk("done_seen", seen, 1);
    if (seen && lat >= 0) chk("done_latency", cyc_cnt - t, lat);
  endtask

  task automatic run_cmd(input logic [7:0] adr, input logic we, input int len,
                         input logic [1:0] bte, input logic [3:0] sel, input int errb);
    int t;
    inj_beat = errb;
    expect_cmd(adr, we, len, bte, sel, errb);
    issue(adr, we, len, bte, sel, t);
    wait_done(t, (errb != 0) ? -1 : (len >= 1 && len <= MAXLEN) ? len + 1 : 0);
    inj_beat = 0;
  endtask

  task automatic write_cmd(input logic [7:0] adr, input int len, input logic [1:0] bte,
                           input logic [3:0] sel, input int errb, input logic [31:0] seed);
    logic [31:0] d;
    for (int k = 0; k < len; k++) begin
      d = seed + 32'(k);
      wq.push_back(d);
      push(d);
    end
    run_cmd(adr, 1'b1, len, bte, sel, errb);
  endtask

  // ---------------- main sequence
  initial begin
    int t;
    logic we;
    int len, errb;
    logic [1:0] bte;
    logic [3:0] sel;
    logic [7:0] adr;

    #1 rst_n = 0;
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_wdat_ready", wdat_ready_o, 1);
    chk("rst_bus", {axi4_cyc_o, axi4_stb_o, axi4_we_o, axi4_adr_o, axi4_cti_o}, 0);
    chk("rst_done_rvld", {done_o, err_o, rdat_valid_o}, 0);
    mem_init();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    mon_en = 1;

    // Linear write then read-back, 4 beats at 0x10
    wq.push_back(32'hA0); wq.push_back(32'hA1); wq.push_back(32'hA2); wq.push_back(32'hA3);
    push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
    run_cmd(8'h10, 1'b1, 4, 2'd0, 4'hF, 0);
    run_cmd(8'h10, 1'b0, 4, 2'd0, 4'hF, 0);

    // Wrap-4 read longer than the wrap window
    run_cmd(8'h08, 1'b0, 6, 2'd1, 4'hF, 0);
    run_cmd(8'h34, 1'b0, 10, 2'd2, 4'hF, 0);
    run_cmd(8'hF8, 1'b0, 5, 2'd0, 4'hF, 0);

    // Write waits for its data
    wq.push_back(32'h5100); wq.push_back(32'h5101); wq.push_back(32'h5102);
    inj_beat = 0;
    expect_cmd(8'h40, 1'b1, 3, 2'd0, 4'hF, 0);
    push(32'h5100);
    issue(8'h40, 1'b1, 3, 2'd0, 4'hF, t);
    repeat (3) begin @(negedge clk); chk("wait_data_no_cyc", axi4_cyc_o, 0); end
    push(32'h5101); push(32'h5102);
    @(negedge clk); chk("wait_data_last_push_cycle", axi4_cyc_o, 0);
    @(negedge clk); chk("wait_data_burst_start", axi4_cyc_o, 1);
    wait_done(t, -1);
    run_cmd(8'h40, 1'b0, 3, 2'd0, 4'hF, 0);

    // Single beat, zero length, oversize
    write_cmd(8'h60, 1, 2'd0, 4'b0101, 0, 32'hC0DE0000);
    run_cmd(8'h60, 1'b0, 1, 2'd0, 4'hF, 0);
    run_cmd(8'h20, 1'b1, 0, 2'd0, 4'hF, 0);
    run_cmd(8'h20, 1'b0, MAXLEN + 1, 2'd0, 4'hF, 0);
    run_cmd(8'h20, 1'b1, MAXLEN + 1, 2'd0, 4'hF, 0);

    // Bus error on beat 2 of a write; leftovers must not leak into the next write
    write_cmd(8'h80, 4, 2'd0, 4'hF, 2, 32'hE0000000);
    write_cmd(8'h90, 2, 2'd0, 4'hF, 0, 32'hF0000000);
    run_cmd(8'h80, 1'b0, 4, 2'd0, 4'hF, 0);
    run_cmd(8'h90, 1'b0, 2, 2'd0, 4'hF, 0);

    // Asynchronous reset in the middle of a read burst, with buffered write data
    mon_en = 0;
    push(32'hDEAD0001); push(32'hDEAD0002);
    issue(8'h20, 1'b0, 8, 2'd0, 4'hF, t);
    repeat (4) @(posedge clk);
    #1 chk("pre_reset_cyc", axi4_cyc_o, 1);
    #1 rst_n = 0;
    #1;
    chk("midrst_cyc_stb", {axi4_cyc_o, axi4_stb_o}, 0);
    chk("midrst_bus", {axi4_adr_o, axi4_cti_o, axi4_we_o, axi4_sel_o}, 0);
    chk("midrst_ready", {cmd_ready_o, wdat_ready_o}, 2'b11);
    chk("midrst_done_rvld", {done_o, rdat_valid_o}, 0);
    bq.delete(); rq.delete(); dq.delete(); wq.delete();
    mem_init();
    @(negedge clk);
    rst_n = 1;
    mon_en = 1;
    write_cmd(8'h24, 2, 2'd0, 4'hF, 0, 32'h12340000);
    run_cmd(8'h24, 1'b0, 2, 2'd0, 4'hF, 0);

    // Randomized commands
    for (int c = 0; c < 60; c++) begin
      we   = 1'($urandom_range(0, 1));
      len  = $urandom_range(0, 20);
      bte  = 2'($urandom_range(0, 3));
      sel  = 4'($urandom_range(1, 15));
      adr  = 8'($urandom);
      errb = (len >= 1 && len <= MAXLEN && $urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
      if (we && len >= 1 && len <= MAXLEN) write_cmd(adr, len, bte, sel, errb, $urandom);
      else run_cmd(adr, we, len, bte, sel, errb);
    end

    repeat (3) @(negedge clk);
    chk("beats_left_over", bq.size(), 0);
    chk("rdat_left_over", rq.size(), 0);
    chk("done_left_over", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
